// File: rtl/tomasulo_pkg.sv
// Shared opcode constants, ROB entry record and opcode helpers for the
// Tomasulo-style issue/commit slice.
package tomasulo_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_LOAD  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;
    localparam logic [3:0] OP_BEQ   = 4'd6;
    localparam logic [3:0] OP_BNEQ  = 4'd7;

    // Control part of a ROB entry; the result value is held in a parallel
    // array sized by the DATA_W parameter of the store.
    typedef struct packed {
        logic       valid;
        logic       ready;
        logic [3:0] func;
        logic [3:0] rd;
    } rob_entry_t;

    // Opcodes add..load write the register bank; store and branches do not.
    function automatic logic op_writes_reg(input logic [3:0] func);
        return (func <= OP_LOAD);
    endfunction

    function automatic logic op_is_branch(input logic [3:0] func);
        return (func == OP_BEQ) || (func == OP_BNEQ);
    endfunction

endpackage

// File: rtl/rob_entry_store.sv
// ROB entry array: allocation write port, CDB result write port, retire
// clear port and a combinational read port at the head pointer.
module rob_entry_store
    import tomasulo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              alloc_we,
    input  logic [IDX_W-1:0]  alloc_idx,
    input  logic [3:0]        alloc_func,
    input  logic [3:0]        alloc_rd,
    input  logic              cdb_we,
    input  logic [IDX_W-1:0]  cdb_idx,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              retire_we,
    input  logic [IDX_W-1:0]  head_idx,
    output rob_entry_t        head_entry,
    output logic [DATA_W-1:0] head_value
);

    rob_entry_t        entries [DEPTH];
    logic [DATA_W-1:0] values  [DEPTH];

    // Entry updates. Alloc and retire never target the same slot (head==tail
    // only when empty or full), and a CDB write only lands on a valid,
    // not-ready entry, so it can neither hit a retiring head nor a fresh slot.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
                values[i]  <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            if (retire_we) begin
                entries[head_idx].valid <= 1'b0;
                entries[head_idx].ready <= 1'b0;
            end
            if (alloc_we) begin
                entries[alloc_idx] <= '{valid: 1'b1, ready: 1'b0,
                                        func: alloc_func, rd: alloc_rd};
            end
            if (cdb_we && entries[cdb_idx].valid && !entries[cdb_idx].ready) begin
                entries[cdb_idx].ready <= 1'b1;
                values[cdb_idx]        <= cdb_data;
            end
        end
    end

    // Head read port feeding the retire decision.
    always_comb begin
        head_entry = entries[head_idx];
        head_value = values[head_idx];
    end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-entry commit.
// Optional feature macro ROB_FLUSH_EN: a retiring beq/bneq whose result bit0
// is set flushes the whole buffer and pulses flush for one cycle. Without it
// branches retire as ordinary non-writing entries and flush stays 0.
module rob_commit
    import tomasulo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [3:0]        alloc_func,
    input  logic [3:0]        alloc_rd,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              cdb_valid,
    input  logic [IDX_W-1:0]  cdb_rob_idx,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              commit_valid,
    output logic              commit_we,
    output logic [3:0]        commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [3:0]        commit_func,
    output logic [CNT_W-1:0]  rob_count,
    output logic              flush
);

    logic [IDX_W-1:0]  head_p;
    logic [IDX_W-1:0]  tail_p;
    rob_entry_t        head_entry;
    logic [DATA_W-1:0] head_value;
    logic              do_alloc;
    logic              do_retire;
    logic              mispredict;

    assign alloc_ready = (rob_count < CNT_W'(DEPTH));
    assign alloc_idx   = tail_p;
    assign do_alloc    = alloc_valid && alloc_ready;
    assign do_retire   = head_entry.valid && head_entry.ready;

`ifdef ROB_FLUSH_EN
    assign mispredict = do_retire && op_is_branch(head_entry.func) && head_value[0];
`else
    assign mispredict = 1'b0;
`endif

    rob_entry_store #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_store (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .clear      (mispredict),
        .alloc_we   (do_alloc && !mispredict),
        .alloc_idx  (tail_p),
        .alloc_func (alloc_func),
        .alloc_rd   (alloc_rd),
        .cdb_we     (cdb_valid && !mispredict),
        .cdb_idx    (cdb_rob_idx),
        .cdb_data   (cdb_data),
        .retire_we  (do_retire),
        .head_idx   (head_p),
        .head_entry (head_entry),
        .head_value (head_value)
    );

    // Head/tail pointers and occupancy; a misprediction resets all three.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head_p    <= '0;
            tail_p    <= '0;
            rob_count <= '0;
        end else if (mispredict) begin
            head_p    <= '0;
            tail_p    <= '0;
            rob_count <= '0;
        end else begin
            if (do_alloc)  tail_p <= tail_p + 1'b1;
            if (do_retire) head_p <= head_p + 1'b1;
            case ({do_alloc, do_retire})
                2'b10:   rob_count <= rob_count + 1'b1;
                2'b01:   rob_count <= rob_count - 1'b1;
                default: rob_count <= rob_count;
            endcase
        end
    end

    // Registered commit port; rd/func/data hold the last retired entry.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_we    <= 1'b0;
            commit_rd    <= '0;
            commit_func  <= '0;
            commit_data  <= '0;
            flush        <= 1'b0;
        end else begin
            commit_valid <= do_retire;
            commit_we    <= do_retire && op_writes_reg(head_entry.func);
            flush        <= mispredict;
            if (do_retire) begin
                commit_rd   <= head_entry.rd;
                commit_func <= head_entry.func;
                commit_data <= head_value;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: a per-cycle vector table for the basic
// alloc/CDB/commit paths plus hand sequences for reset, full/wrap and branches.
module tb_rob_commit;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic [3:0]  alloc_func;
    logic [3:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic        cdb_valid;
    logic [2:0]  cdb_rob_idx;
    logic [15:0] cdb_data;
    logic        commit_valid;
    logic        commit_we;
    logic [3:0]  commit_rd;
    logic [15:0] commit_data;
    logic [3:0]  commit_func;
    logic [3:0]  rob_count;
    logic        flush;

    int n_total = 0;
    int n_pass  = 0;

    rob_commit #(.DEPTH(8), .DATA_W(16)) dut (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_func   (alloc_func),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .cdb_valid    (cdb_valid),
        .cdb_rob_idx  (cdb_rob_idx),
        .cdb_data     (cdb_data),
        .commit_valid (commit_valid),
        .commit_we    (commit_we),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .commit_func  (commit_func),
        .rob_count    (rob_count),
        .flush        (flush)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic        av;
        logic [3:0]  af;
        logic [3:0]  ar;
        logic        cv;
        logic [2:0]  ci;
        logic [15:0] cd;
        logic        e_cv;
        logic        e_we;
        logic [3:0]  e_rd;
        logic [3:0]  e_fn;
        logic [15:0] e_data;
        logic [3:0]  e_cnt;
        logic [2:0]  e_idx;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic av, input logic [3:0] af, input logic [3:0] ar,
                                input logic cv, input logic [2:0] ci, input logic [15:0] cd,
                                input logic e_cv, input logic e_we, input logic [3:0] e_rd,
                                input logic [3:0] e_fn, input logic [15:0] e_data,
                                input logic [3:0] e_cnt, input logic [2:0] e_idx);
        vec_t v;
        v.av = av; v.af = af; v.ar = ar; v.cv = cv; v.ci = ci; v.cd = cd;
        v.e_cv = e_cv; v.e_we = e_we; v.e_rd = e_rd; v.e_fn = e_fn;
        v.e_data = e_data; v.e_cnt = e_cnt; v.e_idx = e_idx;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Drive one cycle of inputs, let the rising edge happen, sample 1 ns later.
    task automatic step(input logic av, input logic [3:0] af, input logic [3:0] ar,
                        input logic cv, input logic [2:0] ci, input logic [15:0] cd);
        alloc_valid = av; alloc_func = af; alloc_rd = ar;
        cdb_valid = cv; cdb_rob_idx = ci; cdb_data = cd;
        @(posedge clk1);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_func = 4'd0; alloc_rd = 4'd0;
        cdb_valid = 1'b0; cdb_rob_idx = 3'd0; cdb_data = 16'd0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        @(negedge clk1);
        rst_n = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        //                av  af  ar  cv ci  cd         cv we rd fn data      cnt idx
        tbl[0]  = mk(1, 4'd0, 4'd3, 0, 3'd0, 16'h0000,  0, 0, 4'd0, 4'd0, 16'h0000, 4'd1, 3'd1);
        tbl[1]  = mk(0, 4'd0, 4'd0, 1, 3'd0, 16'h0042,  0, 0, 4'd0, 4'd0, 16'h0000, 4'd1, 3'd1);
        tbl[2]  = mk(0, 4'd0, 4'd0, 0, 3'd0, 16'h0000,  1, 1, 4'd3, 4'd0, 16'h0042, 4'd0, 3'd1);
        tbl[3]  = mk(0, 4'd0, 4'd0, 0, 3'd0, 16'h0000,  0, 0, 4'd3, 4'd0, 16'h0042, 4'd0, 3'd1);
        tbl[4]  = mk(1, 4'd1, 4'd5, 0, 3'd0, 16'h0000,  0, 0, 4'd3, 4'd0, 16'h0042, 4'd1, 3'd2);
        tbl[5]  = mk(1, 4'd0, 4'd6, 0, 3'd0, 16'h0000,  0, 0, 4'd3, 4'd0, 16'h0042, 4'd2, 3'd3);
        tbl[6]  = mk(0, 4'd0, 4'd0, 1, 3'd2, 16'h0066,  0, 0, 4'd3, 4'd0, 16'h0042, 4'd2, 3'd3);
        tbl[7]  = mk(0, 4'd0, 4'd0, 1, 3'd1, 16'h0055,  0, 0, 4'd3, 4'd0, 16'h0042, 4'd2, 3'd3);
        tbl[8]  = mk(0, 4'd0, 4'd0, 0, 3'd0, 16'h0000,  1, 1, 4'd5, 4'd1, 16'h0055, 4'd1, 3'd3);
        tbl[9]  = mk(0, 4'd0, 4'd0, 0, 3'd0, 16'h0000,  1, 1, 4'd6, 4'd0, 16'h0066, 4'd0, 3'd3);
        tbl[10] = mk(1, 4'd5, 4'd7, 0, 3'd0, 16'h0000,  0, 0, 4'd6, 4'd0, 16'h0066, 4'd1, 3'd4);
        tbl[11] = mk(0, 4'd0, 4'd0, 1, 3'd3, 16'h0010,  0, 0, 4'd6, 4'd0, 16'h0066, 4'd1, 3'd4);
        tbl[12] = mk(0, 4'd0, 4'd0, 0, 3'd0, 16'h0000,  1, 0, 4'd7, 4'd5, 16'h0010, 4'd0, 3'd4);
        tbl[13] = mk(0, 4'd0, 4'd0, 1, 3'd5, 16'hBEEF,  0, 0, 4'd7, 4'd5, 16'h0010, 4'd0, 3'd4);
        tbl[14] = mk(1, 4'd0, 4'd1, 0, 3'd0, 16'h0000,  0, 0, 4'd7, 4'd5, 16'h0010, 4'd1, 3'd5);
        tbl[15] = mk(0, 4'd0, 4'd0, 1, 3'd4, 16'h0011,  0, 0, 4'd7, 4'd5, 16'h0010, 4'd1, 3'd5);
        tbl[16] = mk(0, 4'd0, 4'd0, 1, 3'd4, 16'h0099,  1, 1, 4'd1, 4'd0, 16'h0011, 4'd0, 3'd5);
        tbl[17] = mk(1, 4'd2, 4'd2, 0, 3'd0, 16'h0000,  0, 0, 4'd1, 4'd0, 16'h0011, 4'd1, 3'd6);
        tbl[18] = mk(0, 4'd0, 4'd0, 1, 3'd5, 16'h0022,  0, 0, 4'd1, 4'd0, 16'h0011, 4'd1, 3'd6);
        tbl[19] = mk(1, 4'd0, 4'd4, 0, 3'd0, 16'h0000,  1, 1, 4'd2, 4'd2, 16'h0022, 4'd1, 3'd7);
        tbl[20] = mk(0, 4'd0, 4'd0, 0, 3'd0, 16'h0000,  0, 0, 4'd2, 4'd2, 16'h0022, 4'd1, 3'd7);

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;

        chk("rst_count", 32'(rob_count), 32'd0);
        chk("rst_idx",   32'(alloc_idx), 32'd0);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_cv",    32'(commit_valid), 32'd0);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].av, tbl[i].af, tbl[i].ar, tbl[i].cv, tbl[i].ci, tbl[i].cd);
            chk($sformatf("v%0d_cv", i),    32'(commit_valid), 32'(tbl[i].e_cv));
            chk($sformatf("v%0d_we", i),    32'(commit_we),    32'(tbl[i].e_we));
            chk($sformatf("v%0d_rd", i),    32'(commit_rd),    32'(tbl[i].e_rd));
            chk($sformatf("v%0d_fn", i),    32'(commit_func),  32'(tbl[i].e_fn));
            chk($sformatf("v%0d_data", i),  32'(commit_data),  32'(tbl[i].e_data));
            chk($sformatf("v%0d_cnt", i),   32'(rob_count),    32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_idx", i),   32'(alloc_idx),    32'(tbl[i].e_idx));
            chk($sformatf("v%0d_ready", i), 32'(alloc_ready),  32'(tbl[i].e_cnt < 4'd8));
            chk($sformatf("v%0d_flush", i), 32'(flush),        32'd0);
        end

        // Reset mid-operation with five entries in flight.
        for (int i = 0; i < 4; i++) step(1'b1, 4'd0, 4'(i + 9), 1'b0, 3'd0, 16'd0);
        chk("inflight_cnt", 32'(rob_count), 32'd5);
        chk("inflight_idx", 32'(alloc_idx), 32'd3);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt",   32'(rob_count),    32'd0);
        chk("arst_cv",    32'(commit_valid), 32'd0);
        chk("arst_we",    32'(commit_we),    32'd0);
        chk("arst_rd",    32'(commit_rd),    32'd0);
        chk("arst_fn",    32'(commit_func),  32'd0);
        chk("arst_data",  32'(commit_data),  32'd0);
        chk("arst_flush", 32'(flush),        32'd0);
        chk("arst_idx",   32'(alloc_idx),    32'd0);
        @(negedge clk1);
        rst_n = 1'b1;

        // Fill to full, reject the ninth alloc, retire one, wrap the tail.
        for (int i = 0; i < 8; i++) step(1'b1, 4'd0, 4'(i + 8), 1'b0, 3'd0, 16'd0);
        chk("full_cnt",   32'(rob_count),   32'd8);
        chk("full_ready", 32'(alloc_ready), 32'd0);
        chk("full_idx",   32'(alloc_idx),   32'd0);
        step(1'b1, 4'd0, 4'd3, 1'b0, 3'd0, 16'd0);
        chk("ovf_cnt",   32'(rob_count),   32'd8);
        chk("ovf_ready", 32'(alloc_ready), 32'd0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0077);
        chk("full_cdb_cv", 32'(commit_valid), 32'd0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 16'd0);
        chk("wrap_cv",    32'(commit_valid), 32'd1);
        chk("wrap_rd",    32'(commit_rd),    32'd8);
        chk("wrap_data",  32'(commit_data),  32'h0077);
        chk("wrap_cnt",   32'(rob_count),    32'd7);
        chk("wrap_ready", 32'(alloc_ready),  32'd1);
        chk("wrap_idx",   32'(alloc_idx),    32'd0);
        step(1'b1, 4'd0, 4'd1, 1'b0, 3'd0, 16'd0);
        chk("wrap2_cnt", 32'(rob_count), 32'd8);
        chk("wrap2_idx", 32'(alloc_idx), 32'd1);

        // Taken branch at the head, with an alloc on the retire edge.
        pulse_reset();
        step(1'b1, 4'd6, 4'd2, 1'b0, 3'd0, 16'd0);
        step(1'b1, 4'd0, 4'd3, 1'b0, 3'd0, 16'd0);
        step(1'b1, 4'd0, 4'd4, 1'b0, 3'd0, 16'd0);
        chk("br_cnt", 32'(rob_count), 32'd3);
        step(1'b0, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0001);
        chk("br_cdb_cv", 32'(commit_valid), 32'd0);
        step(1'b1, 4'd0, 4'd5, 1'b0, 3'd0, 16'd0);
        chk("br_cv", 32'(commit_valid), 32'd1);
        chk("br_we", 32'(commit_we),    32'd0);
        chk("br_fn", 32'(commit_func),  32'd6);
`ifdef ROB_FLUSH_EN
        chk("br_flush", 32'(flush),     32'd1);
        chk("br_cnt2",  32'(rob_count), 32'd0);
        chk("br_idx",   32'(alloc_idx), 32'd0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 16'd0);
        chk("br_flush2", 32'(flush),     32'd0);
        chk("br_cnt3",   32'(rob_count), 32'd0);
`else
        chk("br_flush", 32'(flush),     32'd0);
        chk("br_cnt2",  32'(rob_count), 32'd3);
        chk("br_idx",   32'(alloc_idx), 32'd4);
        step(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 16'd0);
        chk("br_flush2", 32'(flush),        32'd0);
        chk("br_cv2",    32'(commit_valid), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
